// File: rtl/contadores_lector_if.sv
// Readout bus between the counter reader (master) and the counter block (slave).
// Latency: none, wires only; valid_in is the slave's combinational reply to req.
// Backpressure: master holds req/idx stable until the slave raises valid_in.
interface contadores_lector_if;
    logic       req;
    logic [2:0] idx;
    logic       valid_in;
    logic [7:0] data_in;

    modport master (output req, idx, input valid_in, data_in);
    modport slave  (input req, idx, output valid_in, data_in);
endinterface

// File: rtl/contadores_lector.sv
// Counter readout initiator: sweeps idx 0..NUM_CNT-1, snapshots each word, checks sum(cnt0..3)==cnt4.
// Latency: start edge to done pulse is NUM_CNT+2 cycles with valid_in held high.
// Backpressure: holds req/idx while valid_in is low; CNT_RD_TIMEOUT_EN aborts after TIMEOUT_CYC stalls.
module contadores_lector #(
    parameter int NUM_CNT     = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic                IDLE,
    contadores_lector_if.master rd,
    output logic [7:0]          cnt0,
    output logic [7:0]          cnt1,
    output logic [7:0]          cnt2,
    output logic [7:0]          cnt3,
    output logic [7:0]          cnt4,
    output logic                busy,
    output logic                done,
    output logic                match,
    output logic                error
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CHECK, S_DONE} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_CNT - 1);

    state_t     state;
    logic       req_q;
    logic [2:0] idx_q;
    logic [7:0] cnt_q [NUM_CNT];
    logic       busy_q;
    logic       done_q;
    logic       match_q;
    logic [9:0] sum;

    // IDLE is informational for the upstream controller; it does not gate the sweep.
    logic unused_idle;
    assign unused_idle = IDLE;

    assign sum = {2'b00, cnt_q[0]} + {2'b00, cnt_q[1]} + {2'b00, cnt_q[2]} + {2'b00, cnt_q[3]};

`ifdef CNT_RD_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wait_cnt;
    logic          err_q;
    assign error = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign error = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state   <= S_IDLE;
            req_q   <= 1'b0;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= 8'd0;
`ifdef CNT_RD_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        req_q   <= 1'b1;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        match_q <= 1'b0;
`ifdef CNT_RD_TIMEOUT_EN
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (rd.valid_in) begin
                        for (int i = 0; i < NUM_CNT; i++)
                            if (idx_q == 3'(i)) cnt_q[i] <= rd.data_in;
`ifdef CNT_RD_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (idx_q == LAST_IDX) begin
                            req_q <= 1'b0;
                            idx_q <= 3'd0;
                            state <= S_CHECK;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
`ifdef CNT_RD_TIMEOUT_EN
                    else if (wait_cnt == WW'(TIMEOUT_CYC - 1)) begin
                        // Abort: keep whatever was captured, skip the conservation check.
                        req_q   <= 1'b0;
                        idx_q   <= 3'd0;
                        err_q   <= 1'b1;
                        match_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
`endif
                end
                S_CHECK: begin
                    match_q <= (sum == {2'b00, cnt_q[LAST_IDX]});
                    done_q  <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd.req = req_q;
    assign rd.idx = idx_q;
    assign cnt0   = cnt_q[0];
    assign cnt1   = cnt_q[1];
    assign cnt2   = cnt_q[2];
    assign cnt3   = cnt_q[3];
    assign cnt4   = cnt_q[LAST_IDX];
    assign busy   = busy_q;
    assign done   = done_q;
    assign match  = match_q;
endmodule

// File: tb/tb_contadores_lector.sv
// Bench for contadores_lector: a responder model answers req, a sweep-level model predicts snapshot, match, timing.
module tb_contadores_lector;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       idle = 1'b1;
    logic       resp_on = 1'b1;
    logic [7:0] cnt0, cnt1, cnt2, cnt3, cnt4;
    logic       busy, done, match, error;
    logic [7:0] resp_vals [8];
    logic [7:0] exp_cnt [5];
    int         errors = 0;
    int         checks = 0;

    contadores_lector_if rd_bus ();

    assign rd_bus.valid_in = rd_bus.req & resp_on;
    assign rd_bus.data_in  = resp_vals[rd_bus.idx];

    contadores_lector dut (
        .CLK(clk), .reset(reset), .start(start), .IDLE(idle), .rd(rd_bus),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4),
        .busy(busy), .done(done), .match(match), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_cnt(input int i);
        case (i)
            0: return cnt0;
            1: return cnt1;
            2: return cnt2;
            3: return cnt3;
            default: return cnt4;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) resp_vals[i] = 8'd0;
        for (int i = 0; i < 5; i++) exp_cnt[i] = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_bus.req, busy, done, match, error} !== 5'b0 || rd_bus.idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_initial req/busy/done/match/error=%b idx=%0d, want 00000 idx=0",
                     {rd_bus.req, busy, done, match, error}, rd_bus.idx);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) resp_vals[i] = 8'(10 + i);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rd_bus.idx !== 3'd2 || rd_bus.req !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_idx idx=%0d req=%b, want idx=2 req=1", rd_bus.idx, rd_bus.req);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_bus.req, busy, done, match, error} !== 5'b0 || rd_bus.idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_midsweep req/busy/done/match/error=%b idx=%0d, want 00000 idx=0",
                     {rd_bus.req, busy, done, match, error}, rd_bus.idx);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_cnt(i) !== exp_cnt[i]) begin
                errors++;
                $display("FAIL reset_cnt%0d got=%0d want=%0d", i, dut_cnt(i), exp_cnt[i]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One sweep against the responder; resp_vals must be set by the caller.
    task automatic do_sweep(input int stall_idx, input int stall_len, input bit extra_starts, input string name);
        bit   to_exp = 1'b0;
        int   exp_lat, edges, stalled, ndone, first_done;
        bit   was_stall;
        logic [9:0] s;
        logic exp_match;
`ifdef CNT_RD_TIMEOUT_EN
        if (stall_len >= TIMEOUT) to_exp = 1'b1;
`endif
        exp_lat    = to_exp ? (1 + stall_idx + TIMEOUT) : (NUM_STEPS() + 2 + stall_len);
        edges      = 0;
        stalled    = 0;
        ndone      = 0;
        first_done = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < exp_lat + 4; k++) begin
            was_stall = 1'b0;
            if (rd_bus.req && rd_bus.idx == 3'(stall_idx) && stalled < stall_len) begin
                resp_on = 1'b0; stalled++; was_stall = 1'b1;
            end else begin
                resp_on = 1'b1;
            end
            idle = resp_on;
            @(negedge clk);
            edges++;
            start = extra_starts && (edges == 2 || edges == 4);
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = edges;
            end
            if (was_stall && !(to_exp && stalled == TIMEOUT)) begin
                checks++;
                if (rd_bus.req !== 1'b1 || rd_bus.idx !== 3'(stall_idx) || dut_cnt(stall_idx) !== exp_cnt[stall_idx]) begin
                    errors++;
                    $display("FAIL %s_stall req=%b idx=%0d cnt=%0d, want req=1 idx=%0d cnt=%0d", name,
                             rd_bus.req, rd_bus.idx, dut_cnt(stall_idx), stall_idx, exp_cnt[stall_idx]);
                end
            end
            if (edges == 1 || edges == exp_lat + 1) begin
                checks++;
                if (busy !== (edges == 1)) begin
                    errors++;
                    $display("FAIL %s_busy at edge %0d got=%b want=%b", name, edges, busy, edges == 1);
                end
            end
        end
        start   = 1'b0;
        resp_on = 1'b1;
        idle    = 1'b1;
        for (int i = 0; i < 5; i++)
            if (!to_exp || i < stall_idx) exp_cnt[i] = resp_vals[i];
        s = 10'(exp_cnt[0]) + 10'(exp_cnt[1]) + 10'(exp_cnt[2]) + 10'(exp_cnt[3]);
        exp_match = !to_exp && (s == 10'(exp_cnt[4]));
        checks++;
        if (first_done != exp_lat || ndone != 1) begin
            errors++;
            $display("FAIL %s_done first at edge %0d count %0d, want edge %0d count 1", name, first_done, ndone, exp_lat);
        end
        checks++;
        if (match !== exp_match || error !== to_exp) begin
            errors++;
            $display("FAIL %s_result match=%b error=%b, want match=%b error=%b", name, match, error, exp_match, to_exp);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_cnt(i) !== exp_cnt[i]) begin
                errors++;
                $display("FAIL %s_cnt%0d got=%0d want=%0d", name, i, dut_cnt(i), exp_cnt[i]);
            end
        end
    endtask

    function automatic int NUM_STEPS();
        return 5;
    endfunction

    task automatic load_vals(input int a, input int b, input int c, input int d, input int e);
        resp_vals[0] = 8'(a); resp_vals[1] = 8'(b); resp_vals[2] = 8'(c);
        resp_vals[3] = 8'(d); resp_vals[4] = 8'(e);
    endtask

    task automatic test_nominal();
        load_vals(3, 4, 5, 6, 18);
        do_sweep(0, 0, 1'b0, "nominal");
    endtask

    task automatic test_mismatch();
        load_vals(31, 31, 31, 31, 8);
        do_sweep(0, 0, 1'b0, "mismatch");
    endtask

    task automatic test_stall();
        load_vals(7, 9, 2, 1, 19);
        do_sweep(1, 10, 1'b0, "stall");
    endtask

    task automatic test_start_ignored();
        load_vals(1, 2, 3, 4, 11);
        do_sweep(0, 0, 1'b1, "start_ignored");
    endtask

    task automatic test_timeout();
        load_vals(20, 21, 22, 23, 86);
        do_sweep(3, 100, 1'b0, "timeout");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int v [4];
            int tot;
            tot = 0;
            for (int i = 0; i < 4; i++) begin
                v[i] = $urandom_range(0, 31);
                tot += v[i];
            end
            if ($urandom_range(0, 1) == 1) load_vals(v[0], v[1], v[2], v[3], tot);
            else load_vals(v[0], v[1], v[2], v[3], $urandom_range(0, 255));
            do_sweep($urandom_range(0, 4), $urandom_range(0, 6), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_stall();
        test_start_ignored();
`ifdef CNT_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/contadores_lector.md
Name: contadores_lector

Overview:
- Initiator/reader for the counter readout interface; the far end of the counter block's req/idx/data/valid protocol.
- On a start pulse it sweeps idx 0..4, holds req until the counter block answers with valid, and captures each 8-bit word into a local snapshot register.
- After the sweep it checks conservation: sum of the four output-FIFO counters equals the input-FIFO counter.
- Sits between the PCIE test controller/probe and the counter block.

Parameters:
- NUM_CNT, 5, number of counters swept (idx 0..NUM_CNT-1); idx NUM_CNT-1 is the input-FIFO counter.
- TIMEOUT_CYC, 16, cycles without valid before abort (used only with CNT_RD_TIMEOUT_EN).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets).
- start  input  1  request one full readout sweep; sampled only in state S_IDLE.
- IDLE  input  1  system idle indication; forwarded information only, not gated here.
- valid_in  input  1  valid from counter block (combinational reply to req).
- data_in  input  8  counter value from counter block.
- req  output  1  read request to counter block.
- idx  output  3  counter index being requested.
- cnt0..cnt3  output  8 each  captured output-FIFO counts (zero-extended 5-bit values).
- cnt4  output  8  captured input-FIFO count.
- busy  output  1  high from the cycle after start accepted until done.
- done  output  1  one-cycle pulse at sweep end.
- match  output  1  conservation check result; valid when done=1; held until next start.
- error  output  1  sweep aborted by timeout (0 without CNT_RD_TIMEOUT_EN).

Behaviour:
- Reset (reset==0 at a rising edge): state=S_IDLE; req=0, idx=0, cnt0..cnt4=0, busy=0, done=0, match=0, error=0, wait counter=0. Applies from any state, including mid-sweep. Effective next edge.
- States: S_IDLE, S_REQ, S_CHECK, S_DONE. All outputs registered.
- S_IDLE: req=0, busy=0. start=1 -> S_REQ; same edge: idx=0, req=1, busy=1, match=0, error=0, wait counter=0.
- S_REQ: req held 1, idx held stable.
  - valid_in=1 at the edge: cnt[idx] <= data_in; wait counter cleared.
  - If idx==NUM_CNT-1: req<=0, go S_CHECK. Otherwise idx<=idx+1, stay in S_REQ.
  - valid_in=0: hold req and idx, retry indefinitely; no capture occurs. Covers IDLE low mid-sweep.
  - Minimum sweep with valid always high: 5 cycles in S_REQ.
- S_CHECK (1 cycle):
  - sum = cnt0+cnt1+cnt2+cnt3 computed at 10 bits, no wrap.
  - match <= (sum == {2'b00,cnt4}).
  - Go S_DONE.
- S_DONE (1 cycle): done=1; busy<=0 on exit; next S_IDLE.
- start while busy: ignored, not queued. start in S_DONE: ignored.
- Latency: start edge to done=1 is NUM_CNT+2 cycles with valid continuously high.
- cnt0..cnt4 and match hold their values until next accepted start. cnt registers are overwritten individually during a sweep.
- idx returns to 0 on leaving S_REQ.

Optional Feature:
- Macro: CNT_RD_TIMEOUT_EN.
- Defined:
  - Wait counter increments each S_REQ cycle with valid_in=0.
  - On reaching TIMEOUT_CYC: req<=0, error<=1, match<=0, go S_DONE (done pulses).
  - Already-captured cnt values are kept; uncaptured ones keep their previous values.
  - error is held until next start or reset.
- Not defined: no wait counter; S_REQ waits forever; error is tied to 0.

Test Plan:
- Reset: reset=0 for 2 cycles mid-sweep (idx=2) -> next cycle req=0, idx=0, busy=0, all cnt=0, state S_IDLE.
- Nominal sweep: responder returns 3, 4, 5, 6, 18 with valid always 1 -> idx steps 0..4 over 5 cycles; done at start+7; cnt0..4=3,4,5,6,18; match=1.
- Mismatch: responder returns 31, 31, 31, 31, 8 -> sum=124 with no 8-bit wrap; match=0; cnt0=31.
- Stall: IDLE/valid_in held 0 for 10 cycles while idx=1 -> req=1, idx=1 held, cnt1 unchanged; resumes on valid; done 10 cycles later than nominal.
- start pulses at cycles 2 and 4 of a sweep -> ignored; exactly one done pulse; busy deasserts after done.
- With CNT_RD_TIMEOUT_EN, TIMEOUT_CYC=16: valid_in stuck 0 at idx=3 -> after 16 cycles req=0, error=1, done pulse, match=0, cnt0..2 captured.
